// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and hazard scoreboard for the 32x32 register file.
// Define RF_ARB_RR_EN for round-robin arbitration (default: A over B).
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_reg,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;
  logic          a_pick;
  logic          a_go;
  logic          b_go;
  logic          set_en;

`ifdef RF_ARB_RR_EN
  logic b_last_q;

  // A wins unless B is also asking and A had the last grant
  always_comb begin
    a_pick = a_valid && (!b_valid || b_last_q);
  end

  // last-granted pointer, moves on every transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      b_last_q <= 1'b1;
    end else if (a_go) begin
      b_last_q <= 1'b0;
    end else if (b_go) begin
      b_last_q <= 1'b1;
    end
  end
`else
  // fixed priority: A always wins
  always_comb begin
    a_pick = a_valid;
  end
`endif

  assign a_ready = !rst && a_pick;
  assign b_ready = !rst && b_valid && !a_pick;
  assign a_go    = a_valid && a_ready;
  assign b_go    = b_valid && b_ready;

  assign stall = busy_q[rs1] || busy_q[rs2] ||
                 (issue_valid && busy_q[issue_reg]);

  assign set_en = issue_valid && !stall &&
                  (issue_reg != '0);

  // clear retiring write, then set new producer so set wins
  always_comb begin
    busy_d = busy_q;
    if (rf_we) begin
      busy_d[rf_waddr] = 1'b0;
    end
    if (set_en) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // output stage: register the winning write; x0 is accepted, never written
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (a_go) begin
      rf_we    <= (a_reg != '0);
      rf_waddr <= a_reg;
      rf_wdata <= a_data;
    end else if (b_go) begin
      rf_we    <= (b_reg != '0);
      rf_waddr <= b_reg;
      rf_wdata <= b_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases plus random
// traffic against a behavioural model of grants, write port and scoreboard.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_reg, rs1, rs2;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg),
    .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg),
    .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid),
    .issue_reg(issue_reg),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

  // reference model state
  bit            m_busy[NR];
  bit            m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_b_last;

  int total = 0;
  int bad = 0;
  bit la, lb, ls;
  bit ga, gb;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_b_last = 1'b1;
  endtask

  function automatic bit exp_stall();
    return m_busy[rs1] || m_busy[rs2] ||
           (issue_valid && m_busy[issue_reg]);
  endfunction

  // who the spec says gets the port this cycle
  task automatic exp_grant(output bit g_a, output bit g_b);
    g_a = 1'b0;
    g_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
`ifdef RF_ARB_RR_EN
        if (m_b_last) g_a = 1'b1;
        else g_b = 1'b1;
`else
        g_a = 1'b1;
`endif
      end else begin
        g_a = a_valid;
        g_b = b_valid;
      end
    end
  endtask

  // called just after an edge with inputs driven; checks mid-cycle,
  // then advances the model over the next edge
  task automatic step(output bit g_a, output bit g_b);
    bit            s;
    bit            n_busy[NR];
    bit            n_we;
    logic [AW-1:0] n_waddr;
    logic [DW-1:0] n_wdata;
    bit            n_b_last;
    @(negedge clk);
    exp_grant(g_a, g_b);
    s = exp_stall();
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("a_ready", a_ready, g_a);
    chk("b_ready", b_ready, g_b);
    chk("stall", stall, s);
    la = a_ready;
    lb = b_ready;
    ls = stall;
    n_busy   = m_busy;
    n_we     = 1'b0;
    n_waddr  = m_waddr;
    n_wdata  = m_wdata;
    n_b_last = m_b_last;
    if (m_we) n_busy[m_waddr] = 1'b0;
    if (issue_valid && !s && issue_reg != 0)
      n_busy[issue_reg] = 1'b1;
    if (g_a) begin
      n_we = (a_reg != 0);
      n_waddr = a_reg;
      n_wdata = a_data;
      n_b_last = 1'b0;
    end else if (g_b) begin
      n_we = (b_reg != 0);
      n_waddr = b_reg;
      n_wdata = b_data;
      n_b_last = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_busy   = n_busy;
      m_we     = n_we;
      m_waddr  = n_waddr;
      m_wdata  = n_wdata;
      m_b_last = n_b_last;
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    issue_valid = 0; issue_reg = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(ga, gb);
    rst = 1'b0;
  endtask

  bit exp_a;

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();

    // reset state; requests during reset are refused
    a_valid = 1; a_reg = 6; b_valid = 1; b_reg = 2;
    issue_valid = 1; issue_reg = 6;
    step(ga, gb);
    chk("rst_a_rdy", la, 1'b0);
    chk("rst_b_rdy", lb, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    idle_inputs();
    rst = 1'b0;
    rs1 = 6;
    step(ga, gb);
    chk("rst_no_busy", ls, 1'b0);

    // A writes x5
    a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
    step(ga, gb);
    chk("x5_a_rdy", la, 1'b1);
    chk("x5_we", rf_we, 1'b1);
    chk("x5_addr", rf_waddr, 5);
    chk("x5_data", rf_wdata, 32'hDEADBEEF);
    a_valid = 0;
    step(ga, gb);
    chk("x5_we_drop", rf_we, 1'b0);

    // both requesters for four cycles
    do_reset();
    a_valid = 1; a_reg = 1; a_data = 32'h11;
    b_valid = 1; b_reg = 2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      step(ga, gb);
      chk("arb_a", la, exp_a);
      chk("arb_b", lb, !exp_a);
    end
    idle_inputs();
    step(ga, gb);

    // RAW on x7 clears two cycles after the transfer
    issue_valid = 1; issue_reg = 7;
    step(ga, gb);
    issue_valid = 0; rs1 = 7;
    step(ga, gb);
    chk("raw_stall", ls, 1'b1);
    a_valid = 1; a_reg = 7; a_data = 32'h77;
    step(ga, gb);
    chk("raw_xfer_stall", ls, 1'b1);
    a_valid = 0;
    step(ga, gb);
    chk("raw_we_stall", ls, 1'b1);
    step(ga, gb);
    chk("raw_clear", ls, 1'b0);
    rs1 = 0;

    // B writes x0: accepted, never written
    b_valid = 1; b_reg = 0; b_data = 32'h1234;
    step(ga, gb);
    chk("x0_b_rdy", lb, 1'b1);
    chk("x0_we", rf_we, 1'b0);
    chk("x0_stall", ls, 1'b0);
    b_valid = 0;
    step(ga, gb);

    // set and clear of x3 on the same edge: set wins
    a_valid = 1; a_reg = 3; a_data = 32'h33;
    step(ga, gb);
    a_valid = 0;
    issue_valid = 1; issue_reg = 3;
    step(ga, gb);
    chk("coll_issue_ok", ls, 1'b0);
    issue_valid = 0; rs1 = 3;
    step(ga, gb);
    chk("coll_busy", ls, 1'b1);
    idle_inputs();

    // reset with a write pending and busy bits set
    issue_valid = 1; issue_reg = 9;
    step(ga, gb);
    issue_valid = 0;
    a_valid = 1; a_reg = 4; a_data = 32'h4444;
    step(ga, gb);
    chk("pend_we", rf_we, 1'b1);
    a_valid = 0;
    rst = 1; issue_valid = 1; issue_reg = 10;
    step(ga, gb);
    chk("mid_rst_a_rdy", la, 1'b0);
    rst = 0; issue_valid = 0; rs1 = 9; rs2 = 10;
    chk("mid_rst_we", rf_we, 1'b0);
    chk("mid_rst_addr", rf_waddr, 0);
    chk("mid_rst_data", rf_wdata, 0);
    step(ga, gb);
    chk("mid_rst_stall", ls, 1'b0);
    idle_inputs();

    // random traffic; requesters hold until accepted
    ga = 1; gb = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_reg   = AW'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_reg   = AW'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      issue_valid = $urandom_range(0, 1);
      issue_reg   = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 9));
      rs2 = AW'($urandom_range(0, 31));
      step(ga, gb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
